nn_argmax_classifier: RTL
=========================

Name: nn_argmax_classifier

Overview:
- Downstream stage of the neural network; sits beside the Avalon register file.
- When the network's output vector becomes valid, the block snapshots the class probabilities.
- It scans them serially, one class per cycle, and produces:
  - the winning digit,
  - its probability,
  - the margin over the runner-up,
  - a confidence flag.
- The register file exposes these results to software, so software no longer runs argmax over 10 registers.

Parameters:
N_CLASSES, 10, number of probability inputs scanned.
WIDTH, 16, bit width of each probability (unsigned).
MARGIN_THRESH, 16'h0800, minimum Margin for Confident to assert.

Ports:
Clk  input  1  system clock; all state changes on rising edge.
Reset  input  1  asynchronous, active-low reset.
Valid  input  1  level-type ready flag from neural network; a rising edge starts a classification.
Probability  input  N_CLASSES x WIDTH  unpacked array [N_CLASSES-1:0] of unsigned class probabilities.
Busy  output  1  high while a snapshot is being scanned.
Done  output  1  one-cycle pulse when results update.
Digit  output  $clog2(N_CLASSES)  index of the maximum probability.
Max_Prob  output  WIDTH  value of the maximum probability.
Margin  output  WIDTH  Max_Prob minus second-highest probability.
Confident  output  1  Margin >= MARGIN_THRESH.

Behaviour:
- Reset (Reset==0, asynchronous):
  - state=IDLE; Busy=0, Done=0, Digit=0, Max_Prob=0, Margin=0, Confident=0.
  - Snapshot regs and valid_d cleared.
  - Reset mid-scan aborts the scan; no Done is produced.
- Edge detect: valid_d registers Valid each cycle. start = Valid & ~valid_d. A level held high starts exactly one classification.
- FSM states: IDLE, SCAN, DONE.
  - IDLE: on start, copy all N_CLASSES probabilities into snapshot regs. Set idx=0, run_max=0, run_second=0, run_idx=0, Busy=1, then go to SCAN.
  - SCAN: each cycle, compare p=snap[idx] as unsigned.
    - If p > run_max: run_second=run_max, run_max=p, run_idx=idx.
    - Else if p > run_second: run_second=p.
    - Then idx++. The cycle that processes idx==N_CLASSES-1 goes to DONE.
  - DONE (1 cycle):
    - Digit=run_idx, Max_Prob=run_max, Margin=run_max-run_second, Confident=(Margin>=MARGIN_THRESH).
    - Done=1, Busy=0, then go to IDLE.
- Latency: start sampled at edge T; scan edges T+1..T+N_CLASSES; outputs and Done visible after edge T+N_CLASSES+1. For the default, Done is high for exactly the cycle following 11 edges.
- Ties: strict '>' means the lowest index wins. An equal value still updates run_second, so Margin=0.
- All-zero vector: Digit=0, Max_Prob=0, Margin=0, Confident=0.
- Margin is always non-negative (run_second <= run_max by construction); no wrap.
- Input changes after the snapshot do not affect the current scan.
- A start edge during SCAN or DONE is ignored; no queueing. valid_d still tracks, so a later edge is needed to restart.
- Results hold between classifications. Done is a strict single-cycle pulse.
- idx counter width is $clog2(N_CLASSES) and never exceeds N_CLASSES-1.

Test Plan:
1. Reset, then Probability={0..9 -> 0x0100*(i+1)}, Valid 0->1 -> Done pulses exactly 11 cycles after start edge; Digit=9, Max_Prob=0x0A00, Margin=0x0100, Confident=0.
2. Probability[3]=0xF000, all others 0x0010, start -> Digit=3, Max_Prob=0xF000, Margin=0xEFF0, Confident=1.
3. Probability[2]=Probability[7]=0x8000, rest 0 -> Digit=2, Margin=0, Confident=0 (tie, lowest index).
4. Hold Valid high 30 cycles -> exactly one Done. Pulse Valid again during SCAN -> ignored. Change Probability during SCAN -> results reflect the snapshot.
5. Drop Reset low at scan cycle 5 -> all outputs 0 immediately (asynchronous), no Done; after release, a new edge gives a correct result.
6. All-zero vector -> Digit=0, Max_Prob=0, Margin=0, Confident=0. Previous results hold until Done.

Source files
------------

// File: rtl/nn_argmax_classifier_if.sv
// Handshake and result bundle between the network, the argmax
// classifier and the register file.
interface nn_argmax_classifier_if #(
    parameter int N_CLASSES = 10,
    parameter int WIDTH     = 16
);
    localparam int IW = $clog2(N_CLASSES);

    logic             Valid;
    logic [WIDTH-1:0] Probability [N_CLASSES-1:0];
    logic             Busy;
    logic             Done;
    logic [IW-1:0]    Digit;
    logic [WIDTH-1:0] Max_Prob;
    logic [WIDTH-1:0] Margin;
    logic             Confident;

    modport master (
        output Valid, Probability,
        input  Busy, Done, Digit, Max_Prob, Margin, Confident
    );

    modport slave (
        input  Valid, Probability,
        output Busy, Done, Digit, Max_Prob, Margin, Confident
    );
endinterface

// File: rtl/nn_argmax_classifier.sv
// Serial argmax over a snapshot of class probabilities: winner,
// its value, margin over the runner-up and a confidence flag.
module nn_argmax_classifier #(
    parameter int               N_CLASSES     = 10,
    parameter int               WIDTH         = 16,
    parameter logic [WIDTH-1:0] MARGIN_THRESH = 'h0800
) (
    input  logic                   Clk,
    input  logic                   Reset,
    nn_argmax_classifier_if.slave  bus
);
    localparam int          IW   = $clog2(N_CLASSES);
    localparam logic [IW-1:0] LAST = IW'(N_CLASSES - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t           state, state_n;
    logic             valid_d;
    logic             start;
    logic [WIDTH-1:0] snap [N_CLASSES-1:0];
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] run_max;
    logic [WIDTH-1:0] run_second;
    logic [IW-1:0]    run_idx;
    logic [WIDTH-1:0] margin_w;
    logic [WIDTH-1:0] p;

    logic             busy_q;
    logic             done_q;
    logic [IW-1:0]    digit_q;
    logic [WIDTH-1:0] max_q;
    logic [WIDTH-1:0] margin_q;
    logic             conf_q;

    assign start    = bus.Valid & ~valid_d;
    assign p        = snap[idx];
    assign margin_w = run_max - run_second;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = SCAN;
            SCAN:    if (idx == LAST) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            valid_d    <= 1'b0;
            idx        <= '0;
            run_max    <= '0;
            run_second <= '0;
            run_idx    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            digit_q    <= '0;
            max_q      <= '0;
            margin_q   <= '0;
            conf_q     <= 1'b0;
            for (int i = 0; i < N_CLASSES; i++) snap[i] <= '0;
        end else begin
            valid_d <= bus.Valid;
            done_q  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < N_CLASSES; i++)
                            snap[i] <= bus.Probability[i];
                        idx        <= '0;
                        run_max    <= '0;
                        run_second <= '0;
                        run_idx    <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                SCAN: begin
                    // Strict compare keeps the lowest index on ties.
                    if (p > run_max) begin
                        run_second <= run_max;
                        run_max    <= p;
                        run_idx    <= idx;
                    end else if (p > run_second) begin
                        run_second <= p;
                    end
                    if (idx != LAST) idx <= idx + 1'b1;
                end
                DONE: begin
                    digit_q  <= run_idx;
                    max_q    <= run_max;
                    margin_q <= margin_w;
                    conf_q   <= (margin_w >= MARGIN_THRESH);
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
    assign bus.Digit     = digit_q;
    assign bus.Max_Prob  = max_q;
    assign bus.Margin    = margin_q;
    assign bus.Confident = conf_q;
endmodule
